ess_brake_detector: RTL and testbench

ESS_BRAKE_DETECTOR -- requirements
Module: ess_brake_detector

---
 rtl/vehicle_pkg.sv | 15 +
 rtl/ess_brake_detector_if.sv | 35 +++
 rtl/ess_speed_sampler.sv | 32 +++
 rtl/ess_brake_detector.sv | 102 ++++++++++
 tb/tb_ess_brake_detector.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/vehicle_pkg.sv
// Shared vehicle types and defaults for the ESS brake detector.
// Optional event counter enabled by ESS_EVENT_CNT_EN.
package vehicle_pkg;

  localparam int SPEED_W_DEF   = 8;
  localparam int MIN_SPEED_DEF = 55;
  localparam int DECEL_TH_DEF  = 25;

  typedef enum logic [1:0] {
    IDLE,
    MONITOR,
    FIRED
  } ess_state_e;

endpackage

// File: rtl/ess_brake_detector_if.sv
// Sample/pedal inputs and ESS outputs of the brake detector.
// Counter field is only live when ESS_EVENT_CNT_EN is defined.
interface ess_brake_if #(
  parameter int SPEED_W = vehicle_pkg::SPEED_W_DEF
);

  logic               tick_1sec;
  logic [SPEED_W-1:0] speed;
  logic               brake_pressed;
  logic               is_accel_pressed;
  logic               ess_trigger;
  logic [SPEED_W-1:0] decel;
  logic [7:0]         ess_event_cnt;

  modport master (
    output tick_1sec,
    output speed,
    output brake_pressed,
    output is_accel_pressed,
    input  ess_trigger,
    input  decel,
    input  ess_event_cnt
  );

  modport slave (
    input  tick_1sec,
    input  speed,
    input  brake_pressed,
    input  is_accel_pressed,
    output ess_trigger,
    output decel,
    output ess_event_cnt
  );

endinterface

// File: rtl/ess_speed_sampler.sv
// Per-second speed sampler: previous speed, valid flag, saturated drop.
// Part of ess_brake_detector (ESS_EVENT_CNT_EN does not affect it).
module ess_speed_sampler #(
  parameter int SPEED_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] prev_speed,
  output logic               valid,
  output logic [SPEED_W-1:0] drop,
  output logic [SPEED_W-1:0] decel
);

  // drop never wraps: a rising speed reads as zero
  assign drop = (speed < prev_speed) ? (prev_speed - speed) : '0;

  // capture each sample; decel only once a prior sample exists
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_speed <= '0;
      valid      <= 1'b0;
      decel      <= '0;
    end else if (tick) begin
      prev_speed <= speed;
      valid      <= 1'b1;
      if (valid) decel <= drop;
    end
  end

endmodule

// File: rtl/ess_brake_detector.sv
// Emergency stop signal detector: hard-braking FSM and trigger pulse.
// Define ESS_EVENT_CNT_EN to build the saturating event counter.
module ess_brake_detector
  import vehicle_pkg::*;
#(
  parameter int SPEED_W   = SPEED_W_DEF,
  parameter int MIN_SPEED = MIN_SPEED_DEF,
  parameter int DECEL_TH  = DECEL_TH_DEF
) (
  input logic        clk,
  input logic        rst_n,
  ess_brake_if.slave bus
);

  localparam logic [SPEED_W-1:0] MIN_S = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] TH    = SPEED_W'(DECEL_TH);

  ess_state_e         state;
  ess_state_e         state_n;
  logic               fire;
  logic               trig_q;
  logic               brake_eff;
  logic [SPEED_W-1:0] prev_speed;
  logic               valid;
  logic [SPEED_W-1:0] drop;
  logic [SPEED_W-1:0] decel;

  ess_speed_sampler #(
    .SPEED_W(SPEED_W)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (bus.tick_1sec),
    .speed     (bus.speed),
    .prev_speed(prev_speed),
    .valid     (valid),
    .drop      (drop),
    .decel     (decel)
  );

  // accelerator always overrides the brake pedal
  assign brake_eff = bus.brake_pressed & ~bus.is_accel_pressed;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next state and fire request; exits win over re-qualification
  always_comb begin
    state_n = state;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (brake_eff && valid) state_n = MONITOR;
      end
      MONITOR: begin
        if (!brake_eff) begin
          state_n = IDLE;
        end else if (bus.tick_1sec && valid &&
                     prev_speed >= MIN_S && drop >= TH) begin
          state_n = FIRED;
          fire    = 1'b1;
        end
      end
      FIRED: begin
        if (bus.is_accel_pressed || !bus.brake_pressed ||
            (bus.tick_1sec && bus.speed == '0)) begin
          state_n = IDLE;
        end else if (bus.tick_1sec && valid && drop >= TH) begin
          fire = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // one-clk trigger pulse, one cycle after the qualifying tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= fire;
  end

  assign bus.ess_trigger = trig_q;
  assign bus.decel       = decel;

`ifdef ESS_EVENT_CNT_EN
  logic [7:0] cnt_q;

  // count trigger pulses, holding at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt_q <= 8'd0;
    else if (trig_q && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end

  assign bus.ess_event_cnt = cnt_q;
`else
  assign bus.ess_event_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ess_brake_detector.sv
// Directed bench for ess_brake_detector.
// Counter expectations follow ESS_EVENT_CNT_EN.
module tb_ess_brake_detector;
  import vehicle_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

`ifdef ESS_EVENT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ess_brake_if #(.SPEED_W(8)) bus ();

  ess_brake_detector #(
    .SPEED_W  (8),
    .MIN_SPEED(55),
    .DECEL_TH (25)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic int cx(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tick sampled at the next edge; returns #1 after that edge
  task automatic tick(input logic [7:0] s, input logic a);
    step();
    bus.speed            = s;
    bus.is_accel_pressed = a;
    bus.tick_1sec        = 1'b1;
    step();
    bus.tick_1sec = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.tick_1sec        = 1'b0;
    bus.speed            = 8'd0;
    bus.brake_pressed    = 1'b0;
    bus.is_accel_pressed = 1'b0;
    step();
    step();
    chk("rst_trig", 32'(bus.ess_trigger), 32'd0);
    chk("rst_decel", 32'(bus.decel), 32'd0);
    chk("rst_cnt", 32'(bus.ess_event_cnt), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;

    // brake held, 100 then 70
    bus.brake_pressed = 1'b1;
    tick(8'd100, 1'b0);
    chk("s1_first_tick", 32'(bus.ess_trigger), 32'd0);
    tick(8'd70, 1'b0);
    chk("s1_pulse", 32'(bus.ess_trigger), 32'd1);
    chk("s1_decel", 32'(bus.decel), 32'd30);
    step();
    chk("s1_width", 32'(bus.ess_trigger), 32'd0);
    chk("s1_state", 32'(dut.state), 32'(FIRED));
    chk("s1_cnt", 32'(bus.ess_event_cnt), 32'(cx(1)));

    // brake off leaves FIRED; 70->50->20 stays below MIN_SPEED test
    bus.brake_pressed = 1'b0;
    step();
    chk("s2_exit", 32'(dut.state), 32'(IDLE));
    bus.brake_pressed = 1'b1;
    tick(8'd50, 1'b0);
    chk("s2_small_drop", 32'(bus.ess_trigger), 32'd0);
    tick(8'd20, 1'b0);
    chk("s2_low_speed", 32'(bus.ess_trigger), 32'd0);
    chk("s2_decel", 32'(bus.decel), 32'd30);

    // 100,70,40,10 from a fresh reset
    do_reset();
    tick(8'd100, 1'b0);
    chk("s3_t0", 32'(bus.ess_trigger), 32'd0);
    tick(8'd70, 1'b0);
    chk("s3_t1", 32'(bus.ess_trigger), 32'd1);
    tick(8'd40, 1'b0);
    chk("s3_t2", 32'(bus.ess_trigger), 32'd1);
    tick(8'd10, 1'b0);
    chk("s3_t3", 32'(bus.ess_trigger), 32'd1);
    step();
    chk("s3_cnt", 32'(bus.ess_event_cnt), 32'(cx(3)));
    tick(8'd0, 1'b0);
    chk("s3_stop_exit", 32'(dut.state), 32'(IDLE));

    // brake and accel together
    do_reset();
    bus.is_accel_pressed = 1'b1;
    tick(8'd100, 1'b1);
    tick(8'd60, 1'b1);
    chk("s4_no_pulse", 32'(bus.ess_trigger), 32'd0);
    step();
    chk("s4_state", 32'(dut.state), 32'(IDLE));

    // accel rising on the qualifying tick
    do_reset();
    tick(8'd100, 1'b0);
    tick(8'd70, 1'b1);
    chk("s5_accel_tick", 32'(bus.ess_trigger), 32'd0);
    chk("s5_state", 32'(dut.state), 32'(IDLE));

    // speed increase gives zero drop
    do_reset();
    bus.brake_pressed    = 1'b0;
    bus.is_accel_pressed = 1'b0;
    tick(8'd60, 1'b0);
    tick(8'd30, 1'b0);
    chk("s6_decel30", 32'(bus.decel), 32'd30);
    tick(8'd80, 1'b0);
    chk("s6_decel0", 32'(bus.decel), 32'd0);

    // reset mid-FIRED, then saturation
    do_reset();
    bus.brake_pressed = 1'b1;
    tick(8'd100, 1'b0);
    tick(8'd70, 1'b0);
    chk("s7_pre_pulse", 32'(bus.ess_trigger), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s7_async_clr", 32'(bus.ess_trigger), 32'd0);
    chk("s7_cnt_clr", 32'(bus.ess_event_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    tick(8'd100, 1'b0);
    chk("s7_post_t0", 32'(bus.ess_trigger), 32'd0);
    tick(8'd60, 1'b0);
    chk("s7_post_t1", 32'(bus.ess_trigger), 32'd1);
    chk("s7_decel", 32'(bus.decel), 32'd40);
    step();
    chk("s7_cnt1", 32'(bus.ess_event_cnt), 32'(cx(1)));
    for (int i = 0; i < 256; i++) begin
      tick(8'd100, 1'b0);
      tick(8'd70, 1'b0);
    end
    chk("s7_last_pulse", 32'(bus.ess_trigger), 32'd1);
    step();
    chk("s7_sat", 32'(bus.ess_event_cnt), 32'(cx(255)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
